// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access-size encodings, FSM state type and lane helpers.
package lsu_pkg;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } lsu_state_t;

   // Byte offset actually used for the access; the reserved size 11 behaves as a word.
   function automatic logic [1:0] eff_offset(input logic [1:0] len, input logic [1:0] off);
      case (len)
         LEN_BYTE: return off;
         LEN_HALF: return {off[1], 1'b0};
         default:  return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] len, input logic [1:0] off);
      case (len)
         LEN_BYTE: return 4'b0001 << off;
         LEN_HALF: return 4'b0011 << {off[1], 1'b0};
         default:  return 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
      case (len)
         LEN_BYTE: return 1'b0;
         LEN_HALF: return off[0];
         default:  return (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational extraction of the addressed byte/half/word lane and sign/zero extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_len,
   input  logic        i_is_signed,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
   assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      case (i_len)
         LEN_BYTE: o_data = {{24{i_is_signed & w_byte[7]}}, w_byte};
         LEN_HALF: o_data = {{16{i_is_signed & w_half[15]}}, w_half};
         default:  o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory access unit; loads return 2+ cycles after request.
// Upstream is stalled while an access is pending; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        is_load_in,
   input  logic        we_mem_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [1:0]  word_length_in,
   input  logic        is_signed_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        stall,
   output logic        misaligned
);

   lsu_state_t  r_state;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic        r_is_load;
   logic [1:0]  r_len;
   logic [1:0]  r_off;
   logic        r_signed;
   logic [31:0] r_load_data;
   logic        r_load_valid;

   logic        w_req_vld;
   logic        w_trap;
   logic        w_accept;
   logic [1:0]  w_off;
   logic [31:0] w_wdata_rep;
   logic [31:0] w_load_data;

   assign w_req_vld = is_load_in | we_mem_in;

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_misaligned;
   assign w_trap     = is_misaligned(word_length_in, addr_in[1:0]);
   assign misaligned = r_misaligned;
`else
   assign w_trap     = 1'b0;
   assign misaligned = 1'b0;
`endif

   assign w_accept = (r_state == IDLE) & w_req_vld & ~w_trap;
   assign w_off    = eff_offset(word_length_in, addr_in[1:0]);

   always_comb begin
      w_wdata_rep = wdata_in;
      case (word_length_in)
         LEN_BYTE: w_wdata_rep = {4{wdata_in[7:0]}};
         LEN_HALF: w_wdata_rep = {2{wdata_in[15:0]}};
         default:  w_wdata_rep = wdata_in;
      endcase
   end

   // Ack cycle releases the pipeline so the next instruction can issue on the return edge.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         if (r_state == IDLE) stall = w_accept;
         else                 stall = ~dmem_ack;
      end
   end

   lsu_load_align u_load_align (
      .i_rdata     (dmem_rdata),
      .i_offset    (r_off),
      .i_len       (r_len),
      .i_is_signed (r_signed),
      .o_data      (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_be         <= '0;
         r_wdata      <= '0;
         r_is_load    <= 1'b0;
         r_len        <= LEN_WORD;
         r_off        <= 2'b00;
         r_signed     <= 1'b0;
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_misaligned <= 1'b0;
`endif
      end else begin
         r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_misaligned <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state   <= BUSY;
                  r_req     <= 1'b1;
                  r_we      <= we_mem_in;
                  r_addr    <= {addr_in[31:2], 2'b00};
                  r_be      <= byte_enables(word_length_in, w_off);
                  r_wdata   <= w_wdata_rep;
                  r_is_load <= is_load_in & ~we_mem_in;
                  r_len     <= word_length_in;
                  r_off     <= w_off;
                  r_signed  <= is_signed_in;
               end
`ifdef LSU_MISALIGN_TRAP_EN
               else if (w_req_vld && w_trap) begin
                  r_misaligned <= 1'b1;
               end
`endif
            end
            BUSY: begin
               if (dmem_ack) begin
                  r_state <= IDLE;
                  r_req   <= 1'b0;
                  if (r_is_load) begin
                     r_load_data  <= w_load_data;
                     r_load_valid <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_be    = r_be;
   assign dmem_wdata = r_wdata;
   assign load_data  = r_load_data;
   assign load_valid = r_load_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus hand sequences for multi-cycle corners.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        is_load_in, we_mem_in;
   logic [31:0] addr_in, wdata_in;
   logic [1:0]  word_length_in;
   logic        is_signed_in;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] load_data;
   logic        load_valid, stall, misaligned;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] prev_ld;

   typedef struct {
      logic        ld;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  len;
      logic        sgn;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_we;
      logic        e_lv;
      logic [31:0] e_ld;
   } vec_t;

   vec_t vq[$];

   load_store_unit dut (
      .clk            (clk),
      .rst            (rst),
      .is_load_in     (is_load_in),
      .we_mem_in      (we_mem_in),
      .addr_in        (addr_in),
      .wdata_in       (wdata_in),
      .word_length_in (word_length_in),
      .is_signed_in   (is_signed_in),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .load_data      (load_data),
      .load_valid     (load_valid),
      .stall          (stall),
      .misaligned     (misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      is_load_in     = 1'b0;
      we_mem_in      = 1'b0;
      addr_in        = 32'h0;
      wdata_in       = 32'h0;
      word_length_in = 2'b10;
      is_signed_in   = 1'b0;
   endtask

   // One request, ack in the first BUSY cycle, result checked the cycle after.
   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] exp_ld;
      @(negedge clk);
      is_load_in     = v.ld;
      we_mem_in      = v.we;
      addr_in        = v.addr;
      wdata_in       = v.wdata;
      word_length_in = v.len;
      is_signed_in   = v.sgn;
      #1 chk($sformatf("v%0d_stall_req", idx), {31'b0, stall}, 32'd1);
      @(negedge clk);
      idle_inputs();
      chk($sformatf("v%0d_req", idx),   {31'b0, dmem_req}, 32'd1);
      chk($sformatf("v%0d_addr", idx),  dmem_addr, v.e_addr);
      chk($sformatf("v%0d_be", idx),    {28'b0, dmem_be}, {28'b0, v.e_be});
      chk($sformatf("v%0d_we", idx),    {31'b0, dmem_we}, {31'b0, v.e_we});
      chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.e_wdata);
      chk($sformatf("v%0d_misal", idx), {31'b0, misaligned}, 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      #1 chk($sformatf("v%0d_stall_ack", idx), {31'b0, stall}, 32'd0);
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      exp_ld = v.e_lv ? v.e_ld : prev_ld;
      prev_ld = exp_ld;
      chk($sformatf("v%0d_req_done", idx), {31'b0, dmem_req}, 32'd0);
      chk($sformatf("v%0d_lv", idx),       {31'b0, load_valid}, {31'b0, v.e_lv});
      chk($sformatf("v%0d_ld", idx),       load_data, exp_ld);
      @(negedge clk);
      chk($sformatf("v%0d_lv_pulse", idx), {31'b0, load_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        ld we addr          wdata         len    sgn rdata         e_addr        e_be   e_wdata       e_we e_lv e_ld
      vq.push_back('{1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
      vq.push_back('{1'b1, 1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 32'h80112233, 32'h100, 4'h8, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80});
      vq.push_back('{1'b1, 1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 32'h80112233, 32'h100, 4'h8, 32'h0,        1'b0, 1'b1, 32'h00000080});
      vq.push_back('{1'b0, 1'b1, 32'h102, 32'h0000ABCD, 2'b01, 1'b0, 32'h55555555, 32'h100, 4'hC, 32'hABCDABCD, 1'b1, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b0, 32'h102, 32'h0,        2'b01, 1'b1, 32'h80112233, 32'h100, 4'hC, 32'h0,        1'b0, 1'b1, 32'hFFFF8011});
      vq.push_back('{1'b1, 1'b0, 32'h100, 32'h0,        2'b01, 1'b0, 32'h12348765, 32'h100, 4'h3, 32'h0,        1'b0, 1'b1, 32'h00008765});
      vq.push_back('{1'b0, 1'b1, 32'h201, 32'h12345678, 2'b00, 1'b0, 32'h0,        32'h200, 4'h2, 32'h78787878, 1'b1, 1'b0, 32'h0});
      vq.push_back('{1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        32'h300, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b1, 32'h104, 32'h0BADF00D, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h104, 4'hF, 32'h0BADF00D, 1'b1, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b0, 32'h108, 32'h0,        2'b11, 1'b1, 32'h01020304, 32'h108, 4'hF, 32'h0,        1'b0, 1'b1, 32'h01020304});
      vq.push_back('{1'b1, 1'b0, 32'h101, 32'h0,        2'b00, 1'b1, 32'h00007F00, 32'h100, 4'h2, 32'h0,        1'b0, 1'b1, 32'h0000007F});
`ifndef LSU_MISALIGN_TRAP_EN
      vq.push_back('{1'b1, 1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 32'h11223344, 32'h100, 4'hF, 32'h0,        1'b0, 1'b1, 32'h11223344});
`endif

      // Reset with a request already presented: stall must stay low.
      idle_inputs();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      rst        = 1'b1;
      is_load_in = 1'b1;
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_req",   {31'b0, dmem_req}, 32'd0);
      chk("rst_we",    {31'b0, dmem_we}, 32'd0);
      chk("rst_addr",  dmem_addr, 32'h0);
      chk("rst_be",    {28'b0, dmem_be}, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_ld",    load_data, 32'h0);
      chk("rst_lv",    {31'b0, load_valid}, 32'd0);
      chk("rst_misal", {31'b0, misaligned}, 32'd0);
      prev_ld = 32'h0;
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("idle_req", {31'b0, dmem_req}, 32'd0);

      foreach (vq[i]) run_vec(vq[i], i);

      // Delayed ack with inputs wiggling during BUSY.
      @(negedge clk);
      is_load_in = 1'b1; addr_in = 32'h200; word_length_in = 2'b10;
      #1 chk("dly_stall0", {31'b0, stall}, 32'd1);
      @(negedge clk);
      is_load_in = 1'b0; we_mem_in = 1'b1; addr_in = 32'h400; wdata_in = 32'hA5A5A5A5;
      word_length_in = 2'b00;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("dly_req%0d", i),   {31'b0, dmem_req}, 32'd1);
         chk($sformatf("dly_addr%0d", i),  dmem_addr, 32'h200);
         chk($sformatf("dly_we%0d", i),    {31'b0, dmem_we}, 32'd0);
         chk($sformatf("dly_be%0d", i),    {28'b0, dmem_be}, 32'hF);
         #1 chk($sformatf("dly_stall%0d", i), {31'b0, stall}, 32'd1);
         @(negedge clk);
      end
      idle_inputs();
      dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
      #1 chk("dly_stall_ack", {31'b0, stall}, 32'd0);
      chk("dly_req_ack", {31'b0, dmem_req}, 32'd1);
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      chk("dly_lv",  {31'b0, load_valid}, 32'd1);
      chk("dly_ld",  load_data, 32'h13579BDF);
      chk("dly_req_done", {31'b0, dmem_req}, 32'd0);
      prev_ld = 32'h13579BDF;

      // Ack while idle is ignored.
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF0000;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("idle_ack_lv", {31'b0, load_valid}, 32'd0);
      chk("idle_ack_ld", load_data, prev_ld);

      // Reset mid-transaction abandons the access.
      is_load_in = 1'b1; addr_in = 32'h500; word_length_in = 2'b10;
      @(negedge clk);
      idle_inputs();
      chk("rb_req_busy", {31'b0, dmem_req}, 32'd1);
      rst = 1'b1;
      #1 chk("rb_stall_rst", {31'b0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rb_req_after", {31'b0, dmem_req}, 32'd0);
      #1 chk("rb_stall_after", {31'b0, stall}, 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      #1 chk("rb_stall_lateack", {31'b0, stall}, 32'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("rb_lv", {31'b0, load_valid}, 32'd0);
      chk("rb_ld", load_data, 32'h0);
      chk("rb_req_idle", {31'b0, dmem_req}, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
      // Misaligned word: trapped, no request, no stall.
      is_load_in = 1'b1; addr_in = 32'h101; word_length_in = 2'b10;
      #1 chk("mis_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      idle_inputs();
      chk("mis_pulse", {31'b0, misaligned}, 32'd1);
      chk("mis_req",   {31'b0, dmem_req}, 32'd0);
      @(negedge clk);
      chk("mis_pulse_end", {31'b0, misaligned}, 32'd0);
      chk("mis_req_end",   {31'b0, dmem_req}, 32'd0);
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
